// File: rtl/ffs_pkg.sv
// Shared types and mask helpers for the find-first-set iterator.
package ffs_pkg;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } ffs_state_e;

   // Helpers operate on a fixed wide mask; callers zero-extend and truncate.
   localparam int FFS_MAX_N = 1024;
   typedef logic [FFS_MAX_N-1:0] ffs_mask_t;

   function automatic ffs_mask_t ffs_onehot_clear(input ffs_mask_t mask,
                                                  input int unsigned idx,
                                                  input int unsigned n);
      return mask & ~(ffs_mask_t'(1) << (n - 32'd1 - idx));
   endfunction

   function automatic logic ffs_is_single(input ffs_mask_t mask);
      return (mask != '0) && ((mask & (mask - ffs_mask_t'(1))) == '0);
   endfunction

endpackage

// File: rtl/ffs_prio_enc.sv
// Combinational MSB-first priority encoder: index 0 is bit N_CANDIDATES-1.
module ffs_prio_enc
   import ffs_pkg::*;
#(
   parameter  int N_CANDIDATES = 8,
   localparam int IDX_W        = $clog2(N_CANDIDATES)
) (
   input  logic [N_CANDIDATES-1:0] i_data,
   output logic [IDX_W-1:0]        o_index,
   output logic                    o_found
);

   localparam int LVL = IDX_W;
   localparam int P   = 1 << LVL;

   // Bit-reversed so the lowest set position is the MSB-first index; padding stays zero.
   logic [P-1:0] rev_s;

   for (genvar g = 0; g < N_CANDIDATES; g++) begin : g_rev
      assign rev_s[g] = i_data[N_CANDIDATES-1-g];
   end

   if (P > N_CANDIDATES) begin : g_pad
      assign rev_s[P-1:N_CANDIDATES] = '0;
   end

   for (genvar l = 0; l <= LVL; l++) begin : g_lvl
      localparam int NN = P >> l;
      logic [NN-1:0]    found_s;
      logic [IDX_W-1:0] idx_s [NN];

      if (l == 0) begin : g_leaf
         assign found_s = rev_s;
         for (genvar j = 0; j < NN; j++) begin : g_node
            assign idx_s[j] = '0;
         end
      end else begin : g_tree
         for (genvar j = 0; j < NN; j++) begin : g_node
            assign found_s[j] = g_lvl[l-1].found_s[2*j] | g_lvl[l-1].found_s[2*j+1];
            assign idx_s[j]   = g_lvl[l-1].found_s[2*j] ? g_lvl[l-1].idx_s[2*j]
                              : (g_lvl[l-1].idx_s[2*j+1] | IDX_W'(32'd1 << (l-1)));
         end
      end
   end

   assign o_found = g_lvl[LVL].found_s[0];
   assign o_index = o_found ? g_lvl[LVL].idx_s[0] : '0;

endmodule

// File: rtl/ffs_iterator.sv
// Walks every set bit of an accepted vector, one MSB-first index per beat.
// Optional FFS_ITER_ABORT_EN adds i_abort to drop the remaining beats.
module ffs_iterator
   import ffs_pkg::*;
#(
   parameter  int N_CANDIDATES = 8,
   localparam int IDX_W        = $clog2(N_CANDIDATES)
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic                    i_valid,
   output logic                    o_ready,
   input  logic [N_CANDIDATES-1:0] i_data,
   output logic                    o_valid,
   input  logic                    i_ready,
`ifdef FFS_ITER_ABORT_EN
   input  logic                    i_abort,
`endif
   output logic [IDX_W-1:0]        o_index,
   output logic                    o_last,
   output logic                    o_empty
);

   ffs_state_e              state_q, state_d;
   logic [N_CANDIDATES-1:0] mask_q,  mask_d;
   logic                    empty_q, empty_d;
   logic [IDX_W-1:0]        enc_idx_s;
   logic                    enc_found_s;
   logic                    last_s;
   logic                    abort_s;

`ifdef FFS_ITER_ABORT_EN
   assign abort_s = i_abort;
`else
   assign abort_s = 1'b0;
`endif

   ffs_prio_enc #(
      .N_CANDIDATES(N_CANDIDATES)
   ) u_enc (
      .i_data (mask_q),
      .o_index(enc_idx_s),
      .o_found(enc_found_s)
   );

   assign last_s = ffs_is_single(ffs_mask_t'(mask_q)) | empty_q;

   // State, mask and empty-flag registers.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= ST_IDLE;
         mask_q  <= '0;
         empty_q <= 1'b0;
      end else begin
         state_q <= state_d;
         mask_q  <= mask_d;
         empty_q <= empty_d;
      end
   end

   // Next state: accept in idle, retire one bit per transfer in run.
   always_comb begin
      state_d = state_q;
      mask_d  = mask_q;
      empty_d = empty_q;
      case (state_q)
         ST_IDLE: begin
            if (i_valid) begin
               mask_d  = i_data;
               empty_d = (i_data == '0);
               state_d = ST_RUN;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            // An abort coinciding with a transfer still counts that beat as delivered.
            if (abort_s) begin
               state_d = ST_IDLE;
               mask_d  = '0;
               empty_d = 1'b0;
            end else if (i_ready) begin
               mask_d = N_CANDIDATES'(ffs_onehot_clear(ffs_mask_t'(mask_q),
                                                       32'(enc_idx_s),
                                                       32'(N_CANDIDATES)));
               if (last_s) begin
                  state_d = ST_IDLE;
                  empty_d = 1'b0;
               end else begin
                  state_d = ST_RUN;
               end
            end else begin
               state_d = ST_RUN;
            end
         end
         default: begin
            state_d = ST_IDLE;
            mask_d  = '0;
            empty_d = 1'b0;
         end
      endcase
   end

   // Outputs are forced quiet while reset is asserted.
   always_comb begin
      o_ready = 1'b0;
      o_valid = 1'b0;
      o_index = '0;
      o_last  = 1'b0;
      o_empty = 1'b0;
      if (!i_rst && (state_q == ST_RUN)) begin
         o_valid = 1'b1;
         o_index = (enc_found_s && !empty_q) ? enc_idx_s : '0;
         o_last  = last_s;
         o_empty = empty_q;
      end else if (!i_rst && (state_q == ST_IDLE)) begin
         o_ready = 1'b1;
      end else begin
         o_ready = 1'b0;
      end
   end

endmodule
